// File: rtl/keypad_debouncer_if.sv
// Signal bundle between the raw 10-key digit pad and its debounced outputs.
interface keypad_debouncer_if;
  logic [9:0] key_raw;
  logic [9:0] A;
  logic [3:0] key_code;
  logic       key_pulse;
  logic       key_err;

  modport master (output key_raw, input A, key_code, key_pulse, key_err);
  modport slave  (input key_raw, output A, key_code, key_pulse, key_err);
endinterface

// File: rtl/keypad_debouncer.sv
// Debounces the 10-key digit pad into a clean one-hot level, binary code and acceptance strobe.
// Optional auto-repeat of the strobe while a key is held: define KEYPAD_REPEAT_EN.
module keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  keypad_debouncer_if.slave kp
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  state_t        state, state_next;
  logic [9:0]    sync_1, s;
  logic [9:0]    cand, cand_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [9:0]    a_q, a_next;
  logic [3:0]    code_q, code_next;
  logic          pulse_q, pulse_next;
  logic          err_q;
  logic          s_zero, s_onehot, s_multi, s_match, cnt_done;
  logic          rep_fire;

  function automatic logic [3:0] index_of(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more keys are down.
  assign s_zero   = (s == 10'd0);
  assign s_multi  = ((s & (s - 10'd1)) != 10'd0);
  assign s_onehot = !s_zero && !s_multi;
  assign s_match  = (s == cand);
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= '0;
      s       <= '0;
      state   <= IDLE;
      cand    <= '0;
      cnt     <= '0;
      a_q     <= '0;
      code_q  <= 4'hF;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_1  <= kp.key_raw;
      s       <= sync_1;
      state   <= state_next;
      cand    <= cand_next;
      cnt     <= cnt_next;
      a_q     <= a_next;
      code_q  <= code_next;
      pulse_q <= pulse_next;
      err_q   <= s_multi;
    end
  end

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (s_onehot) begin
          cand_next  = s;
          cnt_next   = '0;
          state_next = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (s_match) begin
          cnt_next = cnt + 1'b1;
          if (cnt_done) state_next = HELD;
        end else begin
          state_next = IDLE;
        end
      end
      HELD: begin
        if (s_zero) begin
          cnt_next   = '0;
          state_next = REL_DB;
        end
      end
      REL_DB: begin
        if (s_zero) begin
          cnt_next = cnt + 1'b1;
          if (cnt_done) state_next = IDLE;
        end else begin
          state_next = HELD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs only move on a completed press or release window, so A is never anything but zero or cand.
  always_comb begin
    a_next     = a_q;
    code_next  = code_q;
    pulse_next = rep_fire;
    if (state == PRESS_DB && s_match && cnt_done) begin
      a_next     = cand;
      code_next  = index_of(cand);
      pulse_next = 1'b1;
    end
    if (state == REL_DB && s_zero && cnt_done) begin
      a_next    = '0;
      code_next = 4'hF;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt, rep_next;

  assign rep_fire = (state == HELD) && s_match && (rep_cnt == REP_LAST);

  // Restart the period on every entry to HELD; hold the count while extra keys disturb s.
  always_comb begin
    rep_next = rep_cnt;
    if ((state == PRESS_DB || state == REL_DB) && state_next == HELD) begin
      rep_next = '0;
    end else if (state == HELD && s_match) begin
      rep_next = rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_cnt <= '0;
    else     rep_cnt <= rep_next;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign kp.A         = a_q;
  assign kp.key_code  = code_q;
  assign kp.key_pulse = pulse_q;
  assign kp.key_err   = err_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Randomised and directed bench for keypad_debouncer; a digit-level reference model feeds a pulse scoreboard.
module tb_keypad_debouncer;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic clk;
  logic rst;
  keypad_debouncer_if bus ();

  keypad_debouncer #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_count    = 0;
  int last_pulse_cyc = -1;
  int last_clear_cyc = -1;
  logic [9:0] prev_a = '0;
  int sb_q[$];

  // Reference model: digits as integers, sampled keypad two edges late.
  logic [9:0] m_s1 = '0, m_s2 = '0, cur;
  int m_held  = -1;
  int m_cand  = -1;
  int m_run   = -1;
  int m_quiet = 0;
  int m_rep   = 0;
  logic exp_err = 1'b0;

  function automatic logic [9:0] onehot(input int k);
    logic [9:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int digit_of(input logic [9:0] v);
    int d;
    d = -1;
    for (int i = 0; i < 10; i++) if (v[i]) d = i;
    return d;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] raw, input int cycles);
    bus.key_raw = raw;
    repeat (cycles) @(negedge clk);
  endtask

  // A press is accepted after DEB+1 consecutive identical one-hot samples starting from an idle sample;
  // a release after DEB+1 consecutive zero samples. A mismatching sample spends its edge before a restart.
  always @(posedge clk) begin
    cyc++;
    cur = m_s2;
    if (rst) begin
      m_s1 = '0; m_s2 = '0;
      m_held = -1; m_run = -1; m_quiet = 0; m_rep = 0;
      exp_err = 1'b0;
    end else begin
      exp_err = ($countones(cur) > 1);
      if (m_held < 0) begin
        if (m_run < 0) begin
          if ($countones(cur) == 1) begin
            m_cand = digit_of(cur);
            m_run  = 0;
          end
        end else if (cur == onehot(m_cand)) begin
          m_run++;
          if (m_run == DEB) begin
            m_held = m_cand; m_run = -1; m_quiet = 0; m_rep = 0;
            sb_q.push_back(m_held);
          end
        end else begin
          m_run = -1;
        end
      end else if (cur == '0) begin
        m_quiet++;
        if (m_quiet == DEB + 1) begin
          m_held = -1; m_quiet = 0;
        end
      end else if (m_quiet > 0) begin
        m_quiet = 0; m_rep = 0;
      end else begin
`ifdef KEYPAD_REPEAT_EN
        if (cur == onehot(m_held)) begin
          m_rep++;
          if (m_rep == REP) begin
            m_rep = 0;
            sb_q.push_back(m_held);
          end
        end
`endif
      end
      m_s2 = m_s1;
      m_s1 = bus.key_raw;
    end
  end

  // Monitor: level outputs against the model, pulses against the scoreboard queue.
  always @(negedge clk) begin
    checkOutput("A", int'(bus.A), int'(m_held < 0 ? 10'd0 : onehot(m_held)));
    checkOutput("key_code", int'(bus.key_code), m_held < 0 ? 15 : m_held);
    checkOutput("key_err", int'(bus.key_err), int'(exp_err));
    checkOutput("A_onehot_or_zero", int'($countones(bus.A) <= 1), 1);
    checkOutput("key_pulse", int'(bus.key_pulse), int'(sb_q.size() != 0));
    if (bus.key_pulse) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      if (sb_q.size() != 0) checkOutput("pulse_code", int'(bus.key_code), sb_q.pop_front());
    end
    if (prev_a != '0 && bus.A == '0) last_clear_cyc = cyc;
    prev_a = bus.A;
  end

  int c0, pc0, d, e, n;
  int seq[4] = '{2, 5, 8, 1};

  initial begin
    rst = 1'b1;
    bus.key_raw = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_A", int'(bus.A), 0);
    checkOutput("reset_code", int'(bus.key_code), 15);
    checkOutput("reset_pulse", int'(bus.key_pulse), 0);
    checkOutput("reset_err", int'(bus.key_err), 0);
    rst = 1'b0;
    applyStimulus('0, 5);

    $display("[TB] clean press / release");
    c0 = cyc;
    applyStimulus(10'b00000_00100, 20);
    checkOutput("press_latency", last_pulse_cyc - c0, DEB + 3);
    checkOutput("press_code", int'(bus.key_code), 2);
    c0 = cyc;
    applyStimulus('0, 20);
    checkOutput("release_latency", last_clear_cyc - c0, DEB + 3);

    $display("[TB] bouncy press");
    pc0 = pulse_count;
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 10'b00001_00000 : 10'd0, 1);
    checkOutput("bounce_no_pulse", pulse_count - pc0, 0);
    c0 = cyc;
    applyStimulus(10'b00001_00000, 15);
    checkOutput("bounce_latency", last_pulse_cyc - c0, DEB + 3);
    checkOutput("bounce_code", int'(bus.key_code), 5);
    applyStimulus('0, 12);

    $display("[TB] digit sequence");
    pc0 = pulse_count;
    foreach (seq[k]) begin
      applyStimulus(onehot(seq[k]), 10);
      applyStimulus('0, 10);
      checkOutput("gap_A", int'(bus.A), 0);
    end
    checkOutput("seq_pulses", pulse_count - pc0, 4);

    $display("[TB] multi-key");
    pc0 = pulse_count;
    applyStimulus(10'b01000_00010, 10);
    checkOutput("multi_err", int'(bus.key_err), 1);
    checkOutput("multi_A", int'(bus.A), 0);
    checkOutput("multi_no_pulse", pulse_count - pc0, 0);
    applyStimulus('0, 10);
    applyStimulus(onehot(8), 10);
    applyStimulus(onehot(8) | onehot(1), 10);
    checkOutput("second_key_A", int'(bus.A), int'(onehot(8)));
    checkOutput("second_key_err", int'(bus.key_err), 1);
    applyStimulus(onehot(8), 10);
    checkOutput("second_release_A", int'(bus.A), int'(onehot(8)));
    applyStimulus('0, 12);

    $display("[TB] long hold");
    pc0 = pulse_count;
    applyStimulus(onehot(0), 60);
`ifdef KEYPAD_REPEAT_EN
    checkOutput("hold_pulses", pulse_count - pc0, 4);
`else
    checkOutput("hold_pulses", pulse_count - pc0, 1);
`endif
    applyStimulus('0, 12);

    $display("[TB] reset while held");
    applyStimulus(onehot(3), 15);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_held_A", int'(bus.A), 0);
    checkOutput("rst_held_code", int'(bus.key_code), 15);
    checkOutput("rst_held_pulse", int'(bus.key_pulse), 0);
    rst = 1'b0;
    applyStimulus('0, 12);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(0, 9));
      n = int'($urandom_range(1, 25));
      case ($urandom_range(0, 3))
        0: applyStimulus(onehot(d), n);
        1: applyStimulus('0, n);
        2: for (int j = 0; j < n; j++) applyStimulus($urandom_range(0, 1) != 0 ? onehot(d) : 10'd0, 1);
        default: begin
          e = (d + 1 + int'($urandom_range(0, 8))) % 10;
          applyStimulus(onehot(d) | onehot(e), n);
        end
      endcase
    end
    applyStimulus('0, 20);
    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_debouncer.md
# keypad_debouncer

Front-end conditioner for the 10-key digit pad that feeds the detonator's one-hot digit bus `A`. It synchronises the raw mechanical switches and rejects contact bounce. It also qualifies single-key presses and presents a clean one-hot level, a binary code and a one-cycle acceptance strobe. It sits directly upstream of `numeric_code_detonator`, and its `A` output connects straight to that block's `A` input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a press or a release. Must be ≥1.
- `REPEAT_CYCLES`, default 16: auto-repeat period in cycles. Only used with `KEYPAD_REPEAT_EN`.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `key_raw`  in  10: raw digit switches; bit i = digit i, 1 = pressed; asynchronous to `clk`.
- `A`  out  10: debounced one-hot digit level, held for the whole accepted press; all-zero when no key is accepted.
- `key_code`  out  4: binary value (0–9) of the accepted key; 4'hF when none.
- `key_pulse`  out  1: one-cycle strobe on acceptance.
- `key_err`  out  1: level; more than one key is currently down.

## Operation
- **Synchroniser:** two-flop synchroniser on every bit of `key_raw`, giving `s[9:0]`. All decisions below use `s`.
- **State machine:** four states, IDLE, PRESS_DB, HELD and REL_DB. Internal signals: `cand[9:0]` and `cnt`, where `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits.
- **IDLE**
  - `s` one-hot: `cand<=s`, `cnt<=0`, go to PRESS_DB.
  - `s` zero or multi-hot: stay in IDLE.
- **PRESS_DB**
  - `s==cand`: `cnt++`.
  - `s==cand` with `cnt==DEBOUNCE_CYCLES-1`: go to HELD, `A<=cand`, `key_code<=index(cand)`, `key_pulse<=1`.
  - `s!=cand` (bounce, release or second key): go to IDLE; `cnt` and `cand` are discarded and no output changes.
- **HELD**
  - `s==0`: go to REL_DB with `cnt<=0`.
  - Any other value, including extra keys: stay in HELD with `A` unchanged.
- **REL_DB**
  - `s==0`: `cnt++`.
  - `s==0` with `cnt==DEBOUNCE_CYCLES-1`: go to IDLE, `A<=0`, `key_code<=4'hF`.
  - Any nonzero `s`: return to HELD with no new pulse.
- **`key_err`:** registered as (popcount(`s`) > 1). It is state-independent.
- **`key_pulse`:** high for exactly one cycle per acceptance and never in the same cycle as a reset.
- **Guarantee:** `A` is always zero or exactly one-hot.

## Timing
- **Reset values:** sync flops 0, state IDLE, `A=0`, `key_code=4'hF`, `key_pulse=0`, `key_err=0`, `cnt=0`, `cand=0`.
- **Reset mid-operation:** outputs take reset values at the next edge. No pulse is emitted.
- **Press latency:** `key_raw` is stable from clock edge 1. `A`, `key_code` and `key_pulse` update at edge `DEBOUNCE_CYCLES+3` (2 synchroniser edges, 1 IDLE decision, `DEBOUNCE_CYCLES` counting edges).
- **Release latency:** symmetric; `A` clears at edge `DEBOUNCE_CYCLES+3` after `key_raw` goes stably to zero.
- **`key_err` latency:** 3 edges after `key_raw` becomes multi-hot.
- **Bounce shorter than the debounce window:** any glitch lasting at least one synchronised sample restarts acceptance from IDLE (press side) or resumes HELD (release side).
- **Simultaneous press of two keys:** never accepted. `A` stays 0 and `key_err=1`.
- **Second key during HELD:** `A` keeps the first key and `key_err=1`. Releasing only the second key has no effect on `A`.

## Configuration
- Macro: `KEYPAD_REPEAT_EN`.
- **Defined:**
  - A repeat counter clears on entry to HELD from PRESS_DB and on the REL_DB→HELD return.
  - While in HELD with `s==cand`, `key_pulse` fires every `REPEAT_CYCLES` cycles; the first repeat comes `REPEAT_CYCLES` cycles after the acceptance pulse.
  - The counter pauses while `s!=cand`.
- **Undefined:** exactly one `key_pulse` per accepted press. The repeat counter and `REPEAT_CYCLES` logic are absent.

## Test plan
- **Reset:** `rst=1` for 2 cycles → `A=0`, `key_code=F`, `key_pulse=0`, `key_err=0`.
- **Clean press:** `key_raw=10'b00000_00100` held for 20 cycles (DEBOUNCE_CYCLES=4) → at edge 7 `A=10'b00000_00100`, `key_code=2`, single `key_pulse`. Release → `A=0`, `key_code=F` at edge 7 after release.
- **Bouncy press:** `key_raw` toggles 0/`10'b00001_00000` every cycle for 6 cycles, then stable → no pulse during bouncing; acceptance with `key_code=5` exactly 7 edges after the last transition.
- **Digit sequence:** 2, 5, 8, 1, each held 10 cycles with 10-cycle gaps → four pulses with codes 2, 5, 8, 1. `A` is zero between keys.
- **Multi-key:** `key_raw=10'b01000_00010` → `key_err=1` at edge 3, `A` stays 0, no pulse. Separately, press 8 then add 1 while in HELD → `A` remains digit 8, `key_err=1`.
- **Repeat:** with `KEYPAD_REPEAT_EN`, `REPEAT_CYCLES=16`, hold digit 0 for 60 cycles → pulses at acceptance +16, +32, +48. Without the macro → exactly one pulse. Assert `rst` while in HELD → `A=0` at the next edge.
